// File: rtl/bti_mux.sv
// bti_mux: round-robin N-to-1 BTI arbiter with grant lock and an
// in-order outstanding-ID FIFO that routes guest responses back.
module bti_mux #(
  parameter int BTI_AW    = 32,
  parameter int BTI_DW    = 32,
  parameter int HOST_NUM  = 2,
  parameter int OST_DEPTH = 4,
  localparam int MW = BTI_DW / 8,
  localparam int CW = $clog2(OST_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [HOST_NUM-1:0]              i_host_req_vld,
  output logic [HOST_NUM-1:0]              o_host_req_rdy,
  input  logic [HOST_NUM-1:0]              i_host_req_cmd,
  input  logic [HOST_NUM-1:0][BTI_AW-1:0]  i_host_req_addr,
  input  logic [HOST_NUM-1:0][BTI_DW-1:0]  i_host_req_wdata,
  input  logic [HOST_NUM-1:0][MW-1:0]      i_host_req_mask,
  output logic [HOST_NUM-1:0]              o_host_rsp_vld,
  input  logic [HOST_NUM-1:0]              i_host_rsp_rdy,
  output logic [HOST_NUM-1:0][BTI_DW-1:0]  o_host_rsp_rdata,
  output logic [HOST_NUM-1:0]              o_host_rsp_ok,
  output logic                             o_gst_req_vld,
  input  logic                             i_gst_req_rdy,
  output logic                             o_gst_req_cmd,
  output logic [BTI_AW-1:0]                o_gst_req_addr,
  output logic [BTI_DW-1:0]                o_gst_req_wdata,
  output logic [MW-1:0]                    o_gst_req_mask,
  input  logic                             i_gst_rsp_vld,
  output logic                             o_gst_rsp_rdy,
  input  logic [BTI_DW-1:0]                i_gst_rsp_rdata,
  input  logic                             i_gst_rsp_ok,
  output logic [CW-1:0]                    ost_cnt
);

  localparam int IW = (HOST_NUM > 1) ? $clog2(HOST_NUM) : 1;
  localparam int PW = (OST_DEPTH > 1) ? $clog2(OST_DEPTH) : 1;

  logic [IW-1:0] r_rr;
  logic [IW-1:0] r_lock_id;
  logic          r_lock;
  logic [IW-1:0] r_mem [OST_DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  logic [IW-1:0] w_gnt;
  logic [IW-1:0] w_head;
  logic          w_any;
  logic          w_full;
  logic          w_empty;
  logic          w_gvld;
  logic          w_push;
  logic          w_pop;
  logic          w_grdy;

  function automatic logic [IW-1:0] rr_idx(
    input logic [IW-1:0] p,
    input int            k
  );
    int s;
    s = (int'(p) + k) % HOST_NUM;
    return IW'(s);
  endfunction

  function automatic logic [IW-1:0] rr_nxt(
    input logic [IW-1:0] g
  );
    return (int'(g) == HOST_NUM - 1) ? '0 : g + 1'b1;
  endfunction

  // Lowest offset from r_rr wins, so scan from the far end down.
  always_comb begin
    w_gnt = r_rr;
    w_any = 1'b0;
    if (r_lock) begin
      w_gnt = r_lock_id;
      w_any = i_host_req_vld[r_lock_id];
    end else begin
      for (int k = HOST_NUM - 1; k >= 0; k--) begin
        if (i_host_req_vld[rr_idx(r_rr, k)]) begin
          w_gnt = rr_idx(r_rr, k);
          w_any = 1'b1;
        end
      end
    end
  end

  assign w_full  = (r_cnt == CW'(OST_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_gvld  = w_any && !w_full && !rst;
  assign w_push  = w_gvld && i_gst_req_rdy;
  assign w_head  = r_mem[r_rp];
  assign w_grdy  = !w_empty && !rst && i_host_rsp_rdy[w_head];
  assign w_pop   = i_gst_rsp_vld && w_grdy;

  assign o_gst_req_vld   = w_gvld;
  assign o_gst_req_cmd   = i_host_req_cmd[w_gnt];
  assign o_gst_req_addr  = i_host_req_addr[w_gnt];
  assign o_gst_req_wdata = i_host_req_wdata[w_gnt];
  assign o_gst_req_mask  = i_host_req_mask[w_gnt];
  assign o_gst_rsp_rdy   = w_grdy;
  assign ost_cnt         = r_cnt;

  always_comb begin
    o_host_req_rdy   = '0;
    o_host_rsp_vld   = '0;
    o_host_rsp_rdata = '0;
    o_host_rsp_ok    = '0;
    for (int i = 0; i < HOST_NUM; i++) begin
      o_host_req_rdy[i] = w_push && (w_gnt == IW'(i));
      o_host_rsp_vld[i] = i_gst_rsp_vld && !w_empty
                       && !rst && (w_head == IW'(i));
      o_host_rsp_rdata[i] = i_gst_rsp_rdata;
      o_host_rsp_ok[i]    = i_gst_rsp_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr      <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_push) begin
        r_rr   <= rr_nxt(w_gnt);
        r_lock <= 1'b0;
        r_wp   <= r_wp + 1'b1;
      end else if (w_gvld) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_gnt;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // ID storage needs no reset: entries are only read while r_cnt != 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_gnt;
  end

  a_rsp_empty: assert property (
    @(posedge clk) disable iff (rst)
    !(i_gst_rsp_vld && w_empty)
  );

endmodule

// File: tb/tb_bti_mux.sv
// tb_bti_mux: directed and randomized checks of bti_mux against a
// queue-based model of arbitration and in-order response routing.
module tb_bti_mux;

  localparam int H  = 2;
  localparam int D  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst;
  logic [H-1:0]         hv, hrdy, hcmd;
  logic [H-1:0][AW-1:0] haddr;
  logic [H-1:0][DW-1:0] hwdata;
  logic [H-1:0][MW-1:0] hmask;
  logic [H-1:0]         hrv, hrr, hrok;
  logic [H-1:0][DW-1:0] hrdata;
  logic          gv, grr, gcmd;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] gwdata;
  logic [MW-1:0] gmask;
  logic          grv, gro, grok;
  logic [DW-1:0] grdata;
  logic [CW-1:0] ost;

  int checks = 0;
  int failures = 0;

  int m_rr = 0;
  int m_lock = -1;
  int m_q[$];
  logic [DW-1:0] gq[$];

  logic [H-1:0] hen;
  int hprob, rprob, grr_p, hrr_p;
  bit rsp_en;

  always #5 clk = ~clk;

  bti_mux #(
    .BTI_AW(AW), .BTI_DW(DW),
    .HOST_NUM(H), .OST_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .i_host_req_vld(hv),
    .o_host_req_rdy(hrdy),
    .i_host_req_cmd(hcmd),
    .i_host_req_addr(haddr),
    .i_host_req_wdata(hwdata),
    .i_host_req_mask(hmask),
    .o_host_rsp_vld(hrv),
    .i_host_rsp_rdy(hrr),
    .o_host_rsp_rdata(hrdata),
    .o_host_rsp_ok(hrok),
    .o_gst_req_vld(gv),
    .i_gst_req_rdy(grr),
    .o_gst_req_cmd(gcmd),
    .o_gst_req_addr(gaddr),
    .o_gst_req_wdata(gwdata),
    .o_gst_req_mask(gmask),
    .i_gst_rsp_vld(grv),
    .o_gst_rsp_rdy(gro),
    .i_gst_rsp_rdata(grdata),
    .i_gst_rsp_ok(grok),
    .ost_cnt(ost)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pick(input int p);
    return $urandom_range(99) < p;
  endfunction

  // One clock: called at posedge+1, checks at the falling edge,
  // advances the model at the rising edge, then drives new inputs.
  task automatic cyc();
    int g;
    int head;
    bit ev, hs, pop;
    g = -1;
    if (m_lock >= 0) begin
      g = m_lock;
    end else begin
      for (int k = 0; k < H; k++) begin
        int j;
        j = (m_rr + k) % H;
        if (g < 0 && hv[j]) g = j;
      end
    end
    ev   = (g >= 0) && (m_q.size() < D);
    hs   = ev && grr;
    head = (m_q.size() > 0) ? m_q[0] : -1;
    pop  = grv && head >= 0 && hrr[head];
    #4;
    chk("gst_vld", 64'(gv), 64'(ev));
    chk("ost_cnt", 64'(ost), 64'(m_q.size()));
    chk("gst_rsp_rdy", 64'(gro),
        64'(head >= 0 && hrr[head]));
    chk("rsp_rdata", 64'(hrdata[H-1]), 64'(grdata));
    for (int i = 0; i < H; i++) begin
      chk($sformatf("req_rdy%0d", i),
          64'(hrdy[i]), 64'(hs && g == i));
      chk($sformatf("rsp_vld%0d", i),
          64'(hrv[i]), 64'(grv && head == i));
    end
    if (ev) begin
      chk("gst_addr", 64'(gaddr), 64'(haddr[g]));
      chk("gst_wdata", 64'(gwdata), 64'(hwdata[g]));
      chk("gst_cm", 64'({gcmd, gmask}),
          64'({hcmd[g], hmask[g]}));
    end
    @(posedge clk);
    if (pop) begin
      void'(m_q.pop_front());
      void'(gq.pop_front());
    end
    if (hs) begin
      m_rr = (g + 1) % H;
      m_lock = -1;
      m_q.push_back(g);
      gq.push_back(haddr[g] ^ 32'h5a5a_0f0f);
    end else if (ev) begin
      m_lock = g;
    end
    #1;
    if (hs) hv[g] = 1'b0;
    if (pop) grv = 1'b0;
    for (int i = 0; i < H; i++) begin
      if (!hv[i] && hen[i] && pick(hprob)) begin
        hv[i]     = 1'b1;
        hcmd[i]   = 1'($urandom);
        haddr[i]  = $urandom;
        hwdata[i] = $urandom;
        hmask[i]  = MW'($urandom);
      end
      hrr[i] = pick(hrr_p);
    end
    if (!grv && rsp_en && gq.size() > 0 && pick(rprob)) begin
      grv    = 1'b1;
      grdata = gq[0];
      grok   = 1'($urandom);
    end
    grr = pick(grr_p);
  endtask

  task automatic new_req(input int i);
    hv[i]     = 1'b1;
    hcmd[i]   = 1'b0;
    haddr[i]  = $urandom;
    hwdata[i] = $urandom;
    hmask[i]  = '1;
  endtask

  initial begin
    rst = 1'b1;
    hv = '1; hcmd = '0; haddr = '0;
    hwdata = '0; hmask = '0; hrr = '1;
    grr = 1'b1; grv = 1'b0; grdata = '0; grok = 1'b0;
    hen = '0; hprob = 100; rprob = 100;
    grr_p = 100; hrr_p = 100; rsp_en = 1'b1;

    // reset state while hosts request
    #3;
    chk("rst_gvld", 64'(gv), 64'(0));
    chk("rst_hrdy", 64'(hrdy), 64'(0));
    chk("rst_hrsp", 64'(hrv), 64'(0));
    chk("rst_ost", 64'(ost), 64'(0));
    hv = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    // single read from host 0, 1-cycle response
    new_req(0);
    repeat (3) cyc();
    chk("rd_ost0", 64'(ost), 64'(0));

    // both hosts continuously requesting
    hen = '1;
    new_req(0);
    new_req(1);
    repeat (10) cyc();
    hen = '0;
    repeat (8) cyc();

    // grant lock: host 1 stalled, host 0 arrives
    hv = '0;
    new_req(1);
    grr = 1'b0;
    cyc();
    new_req(0);
    grr = 1'b0;
    cyc();
    grr = 1'b0;
    cyc();
    chk("lock_h0", 64'(hrdy), 64'(0));
    grr = 1'b1;
    cyc();
    cyc();
    repeat (4) cyc();

    // full FIFO: guest withholds responses
    hen = 2'b01; rsp_en = 1'b0;
    hv = '0; grv = 1'b0;
    new_req(0);
    repeat (6) cyc();
    chk("full_cnt", 64'(ost), 64'(D));
    chk("full_rdy", 64'(hrdy), 64'(0));
    grv = 1'b1;
    grdata = gq[0];
    hrr = '1;
    hen = '0;
    cyc();
    chk("full_pop", 64'(ost), 64'(D - 1));
    cyc();
    chk("full_5th", 64'(ost), 64'(D));

    // response back-pressure, then reset mid-operation
    rsp_en = 1'b1; hrr_p = 0;
    hrr = '0;
    repeat (3) cyc();
    hrr_p = 100;
    for (int n = 0; n < 50 && m_q.size() > 0; n++) cyc();
    hen = 2'b01; rsp_en = 1'b0;
    new_req(0);
    repeat (3) cyc();
    hen = '0;
    if (!hv[0]) new_req(0);
    grr = 1'b0;
    grv = 1'b1;
    grdata = gq[0];
    chk("pre_rst_ost", 64'(ost), 64'(3));
    rst = 1'b1;
    #1;
    chk("mid_rst_gvld", 64'(gv), 64'(0));
    chk("mid_rst_hrdy", 64'(hrdy), 64'(0));
    chk("mid_rst_hrsp", 64'(hrv), 64'(0));
    chk("mid_rst_ost", 64'(ost), 64'(0));
    m_q.delete(); gq.delete();
    m_rr = 0; m_lock = -1;
    grv = 1'b0; grr = 1'b1;
    new_req(1);
    #1 rst = 1'b0;
    cyc();
    rsp_en = 1'b1;

    // randomized traffic
    hen = '1;
    for (int b = 0; b < 30; b++) begin
      hprob = $urandom_range(100);
      rprob = $urandom_range(100);
      grr_p = $urandom_range(100);
      hrr_p = $urandom_range(100);
      repeat (80) cyc();
    end

    // drain
    hen = '0; rprob = 100; grr_p = 100; hrr_p = 100;
    for (int n = 0; n < 200; n++) begin
      if (m_q.size() > 0 || hv != '0) cyc();
    end
    chk("drain", 64'(m_q.size()), 64'(0));
    chk("drain_ost", 64'(ost), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bti_mux.md
Name: bti_mux

Overview:
- N-to-1 BTI arbiter: the converse of the BTI demux. Merges HOST_NUM BTI initiators onto one BTI guest.
- Typical use: the core's data port and a DMA/debug port sharing one DTCM or flash port.
- Arbitration is round-robin with grant lock.
- An in-order outstanding-ID FIFO routes each guest response back to the host that issued the request.

Parameters:
- BTI_AW, 32, BTI address width.
- BTI_DW, 32, BTI data width.
- HOST_NUM, 2, number of host ports; legal range 2..8.
- OST_DEPTH, 4, maximum outstanding accepted-but-unresponded requests; power of two, 2..16.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- host_bti_req_slvs  input  bti_req_if_t #(BTI_AW,BTI_DW) [HOST_NUM]  request slaves. Fields: req_vld, req_rdy (driven by this block), payload (cmd, addr, wdata, mask).
- host_bti_rsp_msts  output  bti_rsp_if_t #(BTI_DW) [HOST_NUM]  response masters. Fields: rsp_vld (driven by this block), rsp_rdy, payload (rdata, ok).
- gst_bti_req_mst  output  bti_req_if_t #(BTI_AW,BTI_DW)  request master to the guest.
- gst_bti_rsp_slv  input  bti_rsp_if_t #(BTI_DW)  response slave from the guest.
- ost_cnt  output  $clog2(OST_DEPTH+1)  current outstanding count; for observability.

Behaviour:
- Handshake rule: a transfer occurs when vld && rdy in the same cycle. A vld, once raised, is held with stable payload until its handshake.
- Reset values (async, while rst=1):
  - rr_ptr=0, grant_lock=0, FIFO empty, ost_cnt=0.
  - All host req_rdy=0, all host rsp_vld=0, gst req_vld=0.
- Request path is combinational from the granted host (0-cycle latency):
  - gst req_vld = granted host req_vld && !ost_full.
  - Request payload is muxed from the granted host.
  - Granted host req_rdy = gst req_rdy && !ost_full.
  - All other hosts see req_rdy=0.
- Arbitration:
  - When not locked, the grant goes to the first requesting host searching rr_ptr, rr_ptr+1, ... mod HOST_NUM.
  - When no host requests, there is no grant and gst req_vld=0.
- Grant lock:
  - Set when gst req_vld=1 && gst req_rdy=0.
  - While set, the grant is frozen on that host regardless of other requesters.
  - Cleared on that request's handshake.
- rr_ptr update: on each request handshake from host i, rr_ptr <= (i+1) mod HOST_NUM. Otherwise unchanged.
- Outstanding FIFO:
  - Depth OST_DEPTH. Each entry holds a host ID of width max(1,$clog2(HOST_NUM)).
  - Push the granted host ID on every request handshake, read or write (every BTI request gets exactly one response).
  - ost_full = (ost_cnt==OST_DEPTH). While full, no new request is offered to the guest, even if a pop occurs that cycle. This is a registered-count decision with no same-cycle bypass.
  - Pop on response handshake.
  - Simultaneous push and pop leaves ost_cnt unchanged and advances both pointers. Pointers wrap mod OST_DEPTH.
- Response path (combinational, in order):
  - head = FIFO read entry.
  - host[head] rsp_vld = gst rsp_vld && !ost_empty.
  - Response payload is broadcast to all hosts; only host[head] sees vld.
  - gst rsp_rdy = host[head] rsp_rdy && !ost_empty.
- Response with the FIFO empty is a protocol violation: gst rsp_rdy=0 and the response is dropped from routing. A simulation assertion fires.
- Requests and responses may handshake in the same cycle, including the same host issuing a new request while receiving its previous response.
- Reset mid-operation:
  - All state clears immediately.
  - In-flight responses are discarded, since no FIFO entry exists for them after reset.
  - The system-level rule is that guest and hosts share this reset.

Test Plan:
- Single host 0 read with guest req_rdy=1 and a 1-cycle response -> gst req_vld in the same cycle as host req_vld; response rsp_vld reaches host 0 only; ost_cnt goes 0->1->0.
- Hosts 0 and 1 both requesting continuously, guest always ready -> grants alternate 0,1,0,1 for 8 cycles; each response returns to its issuer in order.
- Host 1 requesting, guest req_rdy=0 for 3 cycles, host 0 raises req_vld in cycle 2 -> grant stays on host 1 until its handshake in cycle 4; host 0 granted in cycle 5.
- Guest withholds all responses, OST_DEPTH=4, host 0 issues 6 requests -> 4 accepted, ost_cnt=4, host req_rdy=0. One response returned -> ost_cnt=3 next cycle, 5th request accepted the following cycle.
- Host 0 rsp_rdy=0 for 2 cycles while the head response is pending -> gst rsp_rdy=0, host 1 receives no rsp_vld, ordering preserved.
- rst pulsed with ost_cnt=3 and a guest request pending -> all outputs 0 and ost_cnt=0 asynchronously; the first post-reset grant goes to host 0.
